mix_columns: RTL and testbench
==============================

Name: mix_columns

Overview:
- AES MixColumns round transform (FIPS-197 §5.1.3) on a full 128-bit state, plus InvMixColumns (§5.3.3) selected per transfer.
- Sits in the AES round datapath after ShiftRows (encrypt) or before InvShiftRows (decrypt).
- Pipelined: one registered stage, one state per clock.

Parameters:
- None. Width is fixed at 128 bits and GF(2^8) polynomial fixed at 0x11B.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_state/inv are valid this cycle
- inv  in  1  0 = MixColumns, 1 = InvMixColumns
- in_state  in  128  input state
- out_valid  out  1  out_state holds a new result
- out_state  out  128  transformed state

Behaviour:
- State layout: column c = in_state[127-32c -: 32], c = 0..3. Within a column, row r byte = bits [31-8r -: 8] of that column (row 0 is MSB byte).
- Example: column 0 = in_state[127:96], byte s0 = [127:120].
- Forward, per column (s0..s3 -> t0..t3), in GF(2^8):
  - t0 = 2s0 ^ 3s1 ^ s2 ^ s3
  - t1 = s0 ^ 2s1 ^ 3s2 ^ s3
  - t2 = s0 ^ s1 ^ 2s2 ^ 3s3
  - t3 = 3s0 ^ s1 ^ s2 ^ 2s3
- Inverse: same structure with coefficient rows {0e,0b,0d,09} rotated per row, i.e. t0 = 0e s0 ^ 0b s1 ^ 0d s2 ^ 09 s3.
- xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0). Higher multiples are built from xtime chains plus XOR. No multipliers, no lookup ROMs.
- The four columns are independent and computed in parallel.
- Latency 1 cycle: when in_valid=1 at rising edge N, out_state carries f(in_state, inv) and out_valid=1 after edge N.
- When in_valid=0 at an edge: out_valid <= 0 and out_state holds its previous value.
- Throughput 1 state/cycle. Back-to-back valids produce back-to-back results. No backpressure.
- inv is sampled together with in_state. Mixing modes on consecutive cycles is legal.
- Reset: on rst_n low, out_state = 128'h0 and out_valid = 0 immediately, without waiting for a clock edge. A transfer in flight when reset asserts is discarded.
- First edge after rst_n deasserts behaves normally.
- Inputs are ignored when in_valid=0, including X on in_state; out_state must not change.
- Fixed points: all-zero state maps to all-zero; a column with all bytes equal maps to itself in both modes.

Decomposition:
- Shared package aes_pkg:
  - AES_POLY = 8'h1B
  - typedefs: byte_t, column_t (4 x byte_t), state_t (128-bit)
  - functions: xtime, and gf_mul2/3/9/11/13/14 built from xtime
- Sub-module mix_single_column:
  - combinational, 32-bit in, inv, 32-bit out
  - instantiated 4 times in mix_columns
  - the top level adds only the output/valid register stage.

Test Plan:
- inv=0, in_state=d4bf5d30e0b452aeb84111f11e2798e5 -> next cycle out_state=046681e5e0cb199a48f8d37a2806264c, out_valid=1.
- inv=0, in_state=49db873b453953897f02d2f177de961a -> 584dcaf11b4b5aacdbe7caa81b6bb0e5. Issue back-to-back with the previous vector: out_valid stays high for two cycles, results appear in order.
- inv=1, in_state=046681e5e0cb199a48f8d37a2806264c -> d4bf5d30e0b452aeb84111f11e2798e5. Then inv=1, in_state=584dcaf11b4b5aacdbe7caa81b6bb0e5 -> 49db873b453953897f02d2f177de961a.
- inv=0, columns db135345 / f20a225c / 01010101 / c6c6c6c6 -> 8e4da1bc / 9fdc589d / 01010101 / c6c6c6c6. All-zero input -> all-zero output.
- Valid gating: after a result, drop in_valid and drive in_state=X -> out_valid=0 and out_state unchanged.
- Async reset: assert rst_n=0 mid-cycle with a pending transfer -> out_state=0 and out_valid=0 before the next edge. After release, vector 1 still yields 046681e5....

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) types and arithmetic helpers.
// Contents: byte/column/state typedefs, the reduction polynomial, xtime, and
// the constant multipliers used by MixColumns / InvMixColumns.
package aes_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned COL_W   = 32;
    localparam int unsigned STATE_W = 128;
    localparam int unsigned N_COLS  = 4;

    // Low byte of the field polynomial x^8 + x^4 + x^3 + x + 1 (0x11B).
    localparam logic [BYTE_W-1:0] AES_POLY = 8'h1B;

    typedef logic [BYTE_W-1:0]  byte_t;
    // Element 3 is row 0 (most significant byte of the column word).
    typedef byte_t [3:0]        column_t;
    typedef logic [STATE_W-1:0] state_t;

    // Multiply by x, reducing modulo the field polynomial.
    function automatic byte_t xtime(input byte_t b);
        byte_t shifted;
        shifted = byte_t'({b[BYTE_W-2:0], 1'b0});
        return b[BYTE_W-1] ? (shifted ^ AES_POLY) : shifted;
    endfunction

    function automatic byte_t gf_mul2(input byte_t b);
        return xtime(b);
    endfunction

    function automatic byte_t gf_mul3(input byte_t b);
        return xtime(b) ^ b;
    endfunction

    // 9 = 8 + 1
    function automatic byte_t gf_mul9(input byte_t b);
        byte_t x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    // 11 = 8 + 2 + 1
    function automatic byte_t gf_mul11(input byte_t b);
        byte_t x2;
        byte_t x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    // 13 = 8 + 4 + 1
    function automatic byte_t gf_mul13(input byte_t b);
        byte_t x4;
        byte_t x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    // 14 = 8 + 4 + 2
    function automatic byte_t gf_mul14(input byte_t b);
        byte_t x2;
        byte_t x4;
        byte_t x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column.
// Ports:
//   col     - input column, col[3] is row 0 (MSB byte)
//   inv     - 0 = MixColumns, 1 = InvMixColumns
//   mixed_c - transformed column (combinational)
module mix_single_column
    import aes_pkg::*;
(
    input  column_t col,
    input  logic    inv,
    output column_t mixed_c
);

    byte_t s0;
    byte_t s1;
    byte_t s2;
    byte_t s3;

    column_t fwd;
    column_t bwd;

    assign s0 = col[3];
    assign s1 = col[2];
    assign s2 = col[1];
    assign s3 = col[0];

    // Forward matrix rows: {2,3,1,1} rotated right per row.
    assign fwd[3] = gf_mul2(s0) ^ gf_mul3(s1) ^ s2          ^ s3;
    assign fwd[2] = s0          ^ gf_mul2(s1) ^ gf_mul3(s2) ^ s3;
    assign fwd[1] = s0          ^ s1          ^ gf_mul2(s2) ^ gf_mul3(s3);
    assign fwd[0] = gf_mul3(s0) ^ s1          ^ s2          ^ gf_mul2(s3);

    // Inverse matrix rows: {e,b,d,9} rotated right per row.
    assign bwd[3] = gf_mul14(s0) ^ gf_mul11(s1) ^ gf_mul13(s2) ^ gf_mul9(s3);
    assign bwd[2] = gf_mul9(s0)  ^ gf_mul14(s1) ^ gf_mul11(s2) ^ gf_mul13(s3);
    assign bwd[1] = gf_mul13(s0) ^ gf_mul9(s1)  ^ gf_mul14(s2) ^ gf_mul11(s3);
    assign bwd[0] = gf_mul11(s0) ^ gf_mul13(s1) ^ gf_mul9(s2)  ^ gf_mul14(s3);

    assign mixed_c = inv ? bwd : fwd;

endmodule

// File: rtl/mix_columns.sv
// AES MixColumns / InvMixColumns over a full 128-bit state, one registered stage.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   in_valid   - in_state/inv are valid this cycle
//   inv        - 0 = MixColumns, 1 = InvMixColumns (sampled with in_state)
//   in_state   - input state, column c at [127-32c -: 32]
//   out_valid  - out_state holds a new result (1 cycle after in_valid)
//   out_state  - transformed state, held while no new transfer arrives
module mix_columns
    import aes_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    input  logic   inv,
    input  state_t in_state,
    output logic   out_valid,
    output state_t out_state
);

    state_t mixed;

    // Four independent column transforms in parallel.
    for (genvar c = 0; c < int'(N_COLS); c++) begin : g_col
        mix_single_column u_col (
            .col     (in_state[STATE_W-1-COL_W*c -: COL_W]),
            .inv     (inv),
            .mixed_c (mixed[STATE_W-1-COL_W*c -: COL_W])
        );
    end

    // Output stage: capture on valid, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_state <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_state <= mixed;
            end
        end
    end

endmodule

// File: tb/tb_mix_columns.sv
// Directed, table-driven bench for mix_columns.
module tb_mix_columns;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         inv;
    logic [127:0] in_state;
    logic         out_valid;
    logic [127:0] out_state;

    int tests;
    int fails;

    mix_columns dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inv       (inv),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_state (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         inv;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] V1_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] V1_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] V2_IN  = 128'h49db873b453953897f02d2f177de961a;
    localparam logic [127:0] V2_OUT = 128'h584dcaf11b4b5aacdbe7caa81b6bb0e5;
    localparam logic [127:0] V3_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] V3_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

    vec_t vecs[10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance past the edge, and leave room to sample.
    task automatic step(input logic v, input logic i, input logic [127:0] s);
        in_valid = v;
        inv      = i;
        in_state = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        vecs[0] = '{1'b0, V1_IN,  V1_OUT};
        vecs[1] = '{1'b0, V2_IN,  V2_OUT};
        vecs[2] = '{1'b1, V1_OUT, V1_IN};
        vecs[3] = '{1'b1, V2_OUT, V2_IN};
        vecs[4] = '{1'b0, V3_IN,  V3_OUT};
        vecs[5] = '{1'b1, V3_OUT, V3_IN};
        vecs[6] = '{1'b0, 128'h0, 128'h0};
        vecs[7] = '{1'b1, 128'h0, 128'h0};
        vecs[8] = '{1'b1, 128'h01010101c6c6c6c6ffffffff5a5a5a5a,
                          128'h01010101c6c6c6c6ffffffff5a5a5a5a};
        vecs[9] = '{1'b0, 128'h8080808001010101ffffffff5a5a5a5a,
                          128'h8080808001010101ffffffff5a5a5a5a};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        inv      = 1'b0;
        in_state = '0;

        #3;
        check("reset_state", out_state, 128'h0);
        check("reset_valid", 128'(out_valid), 128'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Isolated transfers from the table.
        for (int k = 0; k < 10; k++) begin
            step(1'b1, vecs[k].inv, vecs[k].din);
            check($sformatf("vec%0d_state", k), out_state, vecs[k].exp);
            check($sformatf("vec%0d_valid", k), 128'(out_valid), 128'h1);
            step(1'b0, 1'b0, 128'h0);
            check($sformatf("vec%0d_idle", k), 128'(out_valid), 128'h0);
        end

        // Back-to-back forward, then back-to-back inverse, then mixed modes.
        step(1'b1, 1'b0, V1_IN);
        check("b2b0_state", out_state, V1_OUT);
        check("b2b0_valid", 128'(out_valid), 128'h1);
        step(1'b1, 1'b0, V2_IN);
        check("b2b1_state", out_state, V2_OUT);
        check("b2b1_valid", 128'(out_valid), 128'h1);
        step(1'b1, 1'b1, V1_OUT);
        check("b2b2_state", out_state, V1_IN);
        step(1'b1, 1'b1, V2_OUT);
        check("b2b3_state", out_state, V2_IN);
        step(1'b1, 1'b0, V3_IN);
        check("mix0_state", out_state, V3_OUT);
        step(1'b1, 1'b1, V3_OUT);
        check("mix1_state", out_state, V3_IN);
        check("mix1_valid", 128'(out_valid), 128'h1);

        // Valid gating with garbage on the inputs: result must hold.
        step(1'b0, 1'bx, 128'bx);
        check("gate0_valid", 128'(out_valid), 128'h0);
        check("gate0_state", out_state, V3_IN);
        step(1'b0, 1'b0, V1_IN);
        check("gate1_state", out_state, V3_IN);

        // Async reset mid-cycle with a pending transfer.
        step(1'b1, 1'b0, V1_IN);
        check("prerst_state", out_state, V1_OUT);
        in_valid = 1'b1;
        inv      = 1'b0;
        in_state = V2_IN;
        #2;
        rst_n = 1'b0;
        #1;
        check("asyncrst_state", out_state, 128'h0);
        check("asyncrst_valid", 128'(out_valid), 128'h0);
        @(posedge clk);
        #1;
        check("heldrst_state", out_state, 128'h0);
        check("heldrst_valid", 128'(out_valid), 128'h0);
        #2;
        rst_n = 1'b1;
        step(1'b1, 1'b0, V1_IN);
        check("postrst_state", out_state, V1_OUT);
        check("postrst_valid", 128'(out_valid), 128'h1);
        step(1'b0, 1'b0, 128'h0);
        check("postrst_idle", 128'(out_valid), 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
